serial_add_seq: RTL and testbench

Sequencing controller for the four-bit serial adder datapath: two operand shift registers, a carry flip-flop and a full adder.
- Accepts a parallel operand pair over a valid/ready handshake.
- Loads the shift registers, clears the carry and drives shift-enable for exactly WIDTH cycles, LSB first.
- Returns the parallel sum and carry-out over a second valid/ready handshake.
- Sits between a parallel-word requester and the bit-serial datapath.

---
 rtl/serial_add_pkg.sv | 22 ++
 rtl/serial_add_seq_if.sv | 25 ++
 rtl/serial_add_bit.sv | 26 ++
 rtl/serial_add_seq.sv | 109 ++++++++++
 tb/tb_serial_add_seq.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and bit-level arithmetic helpers for the serial adder controller.
package serial_add_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Carry out of a full adder: majority of the three inputs.
   function automatic logic maj(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   // Sum bit of a full adder.
   function automatic logic fa_sum(input logic x, input logic y, input logic z);
      return x ^ y ^ z;
   endfunction

endpackage

// File: rtl/serial_add_seq_if.sv
// Operand request and result response handshakes between requester and controller.
interface serial_add_seq_if import serial_add_pkg::*; #(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] sum_out;
   logic             cout_out;

   modport master (
      output req_valid, a_in, b_in, resp_ready,
      input  req_ready, resp_valid, sum_out, cout_out
   );

   modport slave (
      input  req_valid, a_in, b_in, resp_ready,
      output req_ready, resp_valid, sum_out, cout_out
   );

endinterface

// File: rtl/serial_add_bit.sv
// One-bit full adder with its carry flip-flop; carry is cleared at operand load.
module serial_add_bit import serial_add_pkg::*; (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   input  logic x,
   input  logic y,
   output logic s,
   output logic cin
);

   assign s = fa_sum(x, y, cin);

   // Carry register: cleared on reset or load, advanced on each shift.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cin <= 1'b0;
      end else if (clr) begin
         cin <= 1'b0;
      end else if (en) begin
         cin <= maj(x, y, cin);
      end
   end

endmodule

// File: rtl/serial_add_seq.sv
// Sequencer for the bit-serial adder: load operands, shift WIDTH times LSB first,
// then hold the parallel sum and carry-out until the consumer takes them.
module serial_add_seq import serial_add_pkg::*; #(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic            clk,
   input  logic            rstn,
   serial_add_seq_if.slave bus,
   output logic            busy,
   output logic            se,
   output logic            ser_x,
   output logic            ser_y,
   output logic            ser_cin,
   output logic            ser_sum
);

   localparam int unsigned      CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [CNT_W-1:0] count;
   logic             carry;
   logic             s;
   logic             accept;
   logic             shifting;

   assign accept   = (state == IDLE) && bus.req_valid && bus.req_ready;
   assign shifting = (state == SHIFT);

   serial_add_bit u_bit (
      .clk  (clk),
      .rstn (rstn),
      .clr  (accept),
      .en   (shifting),
      .x    (a_reg[0]),
      .y    (b_reg[0]),
      .s    (s),
      .cin  (carry)
   );

   assign ser_x   = a_reg[0];
   assign ser_y   = b_reg[0];
   assign ser_cin = carry;
   assign ser_sum = s;

   // Controller state, shift registers, bit counter and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state          <= IDLE;
         a_reg          <= '0;
         b_reg          <= '0;
         count          <= '0;
         bus.req_ready  <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.sum_out    <= '0;
         bus.cout_out   <= 1'b0;
         busy           <= 1'b0;
         se             <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_reg         <= bus.a_in;
                  b_reg         <= bus.b_in;
                  count         <= '0;
                  state         <= SHIFT;
                  bus.req_ready <= 1'b0;
                  busy          <= 1'b1;
                  se            <= 1'b1;
               end
            end
            SHIFT: begin
               a_reg <= {s, a_reg[WIDTH-1:1]};
               b_reg <= {1'b0, b_reg[WIDTH-1:1]};
               count <= count + CNT_W'(1);
               if (count == LAST) begin
                  state          <= DONE;
                  se             <= 1'b0;
                  bus.resp_valid <= 1'b1;
                  bus.sum_out    <= {s, a_reg[WIDTH-1:1]};
                  bus.cout_out   <= maj(a_reg[0], b_reg[0], carry);
               end
            end
            DONE: begin
               if (bus.resp_ready) begin
                  state          <= IDLE;
                  bus.resp_valid <= 1'b0;
                  bus.sum_out    <= '0;
                  bus.cout_out   <= 1'b0;
                  bus.req_ready  <= 1'b1;
                  busy           <= 1'b0;
               end
            end
            default: begin
               state          <= IDLE;
               bus.req_ready  <= 1'b1;
               bus.resp_valid <= 1'b0;
               bus.sum_out    <= '0;
               bus.cout_out   <= 1'b0;
               busy           <= 1'b0;
               se             <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq at WIDTH=4 and WIDTH=8 against a timing/arithmetic model.
module tb_serial_add_seq;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   serial_add_seq_if #(.WIDTH(4)) if4 ();
   serial_add_seq_if #(.WIDTH(8)) if8 ();

   logic busy4, se4, sx4, sy4, sc4, ss4;
   logic busy8, se8, sx8, sy8, sc8, ss8;

   serial_add_seq #(.WIDTH(4)) dut4 (
      .clk(clk), .rstn(rstn), .bus(if4), .busy(busy4), .se(se4),
      .ser_x(sx4), .ser_y(sy4), .ser_cin(sc4), .ser_sum(ss4)
   );

   serial_add_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rstn(rstn), .bus(if8), .busy(busy8), .se(se8),
      .ser_x(sx8), .ser_y(sy8), .ser_cin(sc8), .ser_sum(ss8)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Model: an accepted pair occupies the unit; d = edges since accept.
   // Shift-enable while d < W, response pending once d >= W until taken.
   bit         m4_busy = 1'b0;
   int         m4_d    = 0;
   logic [4:0] m4_res  = '0;
   bit         m8_busy = 1'b0;
   int         m8_d    = 0;
   logic [8:0] m8_res  = '0;

   logic [3:0] last_sum4 = '0;
   logic       last_cout4 = 1'b0;
   int         resp4 = 0;
   logic [7:0] last_sum8 = '0;
   logic       last_cout8 = 1'b0;
   int         resp8 = 0;
   logic       ssq4[$];

   // Model update and response capture at the active edge (DUT values are pre-edge here).
   always @(posedge clk) begin
      if (rstn && if4.resp_valid && if4.resp_ready) begin
         last_sum4 = if4.sum_out; last_cout4 = if4.cout_out; resp4++;
      end
      if (rstn && if8.resp_valid && if8.resp_ready) begin
         last_sum8 = if8.sum_out; last_cout8 = if8.cout_out; resp8++;
      end
      if (!rstn) m4_busy = 1'b0;
      else if (!m4_busy) begin
         if (if4.req_valid) begin
            m4_busy = 1'b1; m4_d = 0; m4_res = 5'(if4.a_in) + 5'(if4.b_in);
         end
      end else if (m4_d >= 4) begin
         if (if4.resp_ready) m4_busy = 1'b0;
      end else m4_d++;
      if (!rstn) m8_busy = 1'b0;
      else if (!m8_busy) begin
         if (if8.req_valid) begin
            m8_busy = 1'b1; m8_d = 0; m8_res = 9'(if8.a_in) + 9'(if8.b_in);
         end
      end else if (m8_d >= 8) begin
         if (if8.resp_ready) m8_busy = 1'b0;
      end else m8_d++;
   end

   // Per-cycle comparison of all handshake/control outputs against the model.
   always @(negedge clk) begin
      bit rv4, se4e, rv8, se8e;
      if (cmp_en) begin
         rv4  = m4_busy && (m4_d >= 4);
         se4e = m4_busy && (m4_d < 4);
         check("w4_req_ready",  64'(if4.req_ready),  64'(!m4_busy));
         check("w4_busy",       64'(busy4),          64'(m4_busy));
         check("w4_se",         64'(se4),            64'(se4e));
         check("w4_resp_valid", 64'(if4.resp_valid), 64'(rv4));
         check("w4_sum_out",    64'(if4.sum_out),    rv4 ? 64'(m4_res[3:0]) : 64'(0));
         check("w4_cout_out",   64'(if4.cout_out),   rv4 ? 64'(m4_res[4]) : 64'(0));
         rv8  = m8_busy && (m8_d >= 8);
         se8e = m8_busy && (m8_d < 8);
         check("w8_req_ready",  64'(if8.req_ready),  64'(!m8_busy));
         check("w8_busy",       64'(busy8),          64'(m8_busy));
         check("w8_se",         64'(se8),            64'(se8e));
         check("w8_resp_valid", 64'(if8.resp_valid), 64'(rv8));
         check("w8_sum_out",    64'(if8.sum_out),    rv8 ? 64'(m8_res[7:0]) : 64'(0));
         check("w8_cout_out",   64'(if8.cout_out),   rv8 ? 64'(m8_res[8]) : 64'(0));
         if (se4) ssq4.push_back(ss4);
      end
   end

   // One WIDTH=4 operation; lat counts cycles from accept to resp_valid.
   task automatic op4(input logic [3:0] a, input logic [3:0] b, input int hold,
                      input bit scramble, input bit poke, output int lat);
      @(negedge clk);
      if4.a_in = a; if4.b_in = b; if4.req_valid = 1'b1; if4.resp_ready = 1'b0;
      @(negedge clk);
      if4.req_valid = 1'b0;
      lat = 0;
      while (!if4.resp_valid && lat < 40) begin
         if (scramble) begin
            if4.a_in = 4'($urandom); if4.b_in = 4'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      if (!if4.resp_valid) check("w4_resp_timeout", 64'(if4.resp_valid), 64'(1));
      repeat (hold) begin
         if (poke) begin
            if4.req_valid = ~if4.req_valid; if4.a_in = 4'($urandom);
         end
         @(negedge clk);
      end
      if4.req_valid = 1'b0; if4.resp_ready = 1'b1;
      @(negedge clk);
      if4.resp_ready = 1'b0;
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input int hold, output int lat);
      @(negedge clk);
      if8.a_in = a; if8.b_in = b; if8.req_valid = 1'b1; if8.resp_ready = 1'b0;
      @(negedge clk);
      if8.req_valid = 1'b0;
      lat = 0;
      while (!if8.resp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!if8.resp_valid) check("w8_resp_timeout", 64'(if8.resp_valid), 64'(1));
      repeat (hold) @(negedge clk);
      if8.resp_ready = 1'b1;
      @(negedge clk);
      if8.resp_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat;
      int         r4;
      logic [3:0] seq;
      logic [7:0] ra, rb;
      logic [8:0] rs;
      if4.req_valid = 1'b0; if4.resp_ready = 1'b0; if4.a_in = '0; if4.b_in = '0;
      if8.req_valid = 1'b0; if8.resp_ready = 1'b0; if8.a_in = '0; if8.b_in = '0;
      rstn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_req_ready",  64'(if4.req_ready),  64'(1));
      check("rst_resp_valid", 64'(if4.resp_valid), 64'(0));
      check("rst_busy_se",    64'({busy4, se4}),   64'(0));
      check("rst_sum_cout",   64'({if4.sum_out, if4.cout_out}), 64'(0));
      check("rst_ser4",       64'({sx4, sy4, sc4, ss4}), 64'(0));
      check("rst_ser8",       64'({sx8, sy8, sc8, ss8, if8.resp_valid}), 64'(0));
      rstn = 1'b1;
      cmp_en = 1'b1;

      // 5+3: four shifts, serial sum bits 0,0,0,1 LSB first.
      ssq4.delete();
      op4(4'd5, 4'd3, 0, 1'b0, 1'b0, lat);
      check("t1_latency", 64'(lat), 64'(4));
      check("t1_sum",     64'(last_sum4), 64'(8));
      check("t1_cout",    64'(last_cout4), 64'(0));
      check("t1_se_cycles", 64'(ssq4.size()), 64'(4));
      seq = '0;
      for (int i = 0; i < ssq4.size() && i < 4; i++) seq[i] = ssq4[i];
      check("t1_ser_sum_seq", 64'(seq), 64'(4'b1000));

      op4(4'd15, 4'd1, 0, 1'b0, 1'b0, lat);
      check("t2_sum",  64'(last_sum4), 64'(0));
      check("t2_cout", 64'(last_cout4), 64'(1));
      op4(4'd15, 4'd15, 0, 1'b0, 1'b0, lat);
      check("t3_sum",  64'(last_sum4), 64'(14));
      check("t3_cout", 64'(last_cout4), 64'(1));

      // Backpressure with req_valid pulses during DONE.
      op4(4'd9, 4'd6, 5, 1'b0, 1'b1, lat);
      check("t4_sum",  64'(last_sum4), 64'(15));
      check("t4_cout", 64'(last_cout4), 64'(0));

      // Reset on the second SHIFT cycle discards the operation.
      r4 = resp4;
      @(negedge clk);
      if4.a_in = 4'd7; if4.b_in = 4'd7; if4.req_valid = 1'b1;
      @(negedge clk);
      if4.req_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      check("t5_req_ready",  64'(if4.req_ready),  64'(1));
      check("t5_se",         64'(se4),            64'(0));
      check("t5_resp_valid", 64'(if4.resp_valid), 64'(0));
      rstn = 1'b1;
      if4.resp_ready = 1'b1;
      repeat (12) @(negedge clk);
      if4.resp_ready = 1'b0;
      check("t5_no_resp", 64'(resp4), 64'(r4));
      op4(4'd2, 4'd2, 0, 1'b0, 1'b0, lat);
      check("t5_sum", 64'(last_sum4), 64'(4));

      // Operand inputs change after accept.
      op4(4'd3, 4'd4, 1, 1'b1, 1'b0, lat);
      check("t6_sum",  64'(last_sum4), 64'(7));
      check("t6_cout", 64'(last_cout4), 64'(0));

      // WIDTH=8 directed and random regression.
      op8(8'd200, 8'd100, 0, lat);
      check("t7_latency", 64'(lat), 64'(8));
      check("t7_sum",     64'(last_sum8), 64'(44));
      check("t7_cout",    64'(last_cout8), 64'(1));
      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 9'(ra) + 9'(rb);
         op8(ra, rb, int'($urandom_range(0, 2)), lat);
         check("t8_rand_sum", 64'({last_cout8, last_sum8}), 64'(rs));
      end
      check("t8_resp_count", 64'(resp8), 64'(201));

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
